hub75_scan_driver: RTL and testbench

Scan driver for the 64x32, 1/16-scan RGB LED matrix panel. It is the reader side of the pixel-source interface: it drives `col`/`row` to the pixel generator and takes back the six combinational colour bits `R0 G0 B0 R1 G1 B1`. It shifts each row into the panel with `pclk`, latches the row with `lat`, selects it on `addr`, and gates brightness with `oe_n`. It sits between the game's matrix pixel generator and the panel connector pins.

---
 rtl/hub75_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: shifts, latches, displays and blanks one row at a time
// for a 1/16-scan RGB panel, pulling pixel bits from a combinational source.
module hub75_scan_driver #(
   parameter int COLS      = 64,
   parameter int ROWS      = 16,
   parameter int CLK_DIV   = 1,
   parameter int ON_CYC    = 256,
   parameter int BLANK_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [5:0] col,
   output logic [3:0] row,
   input  logic       R0,
   input  logic       G0,
   input  logic       B0,
   input  logic       R1,
   input  logic       G1,
   input  logic       B1,
   output logic       pR0,
   output logic       pG0,
   output logic       pB0,
   output logic       pR1,
   output logic       pG1,
   output logic       pB1,
   output logic       pclk,
   output logic       lat,
   output logic       oe_n,
   output logic [3:0] addr,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DISPLAY, BLANK} state_t;

   localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
   localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
   localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
   localparam logic [31:0] ON_LAST  = 32'(ON_CYC - 1);
   localparam logic [31:0] BL_LAST  = 32'(BLANK_CYC - 1);

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx;
   logic        ph, ph_nx;
   logic [5:0]  col_nx;
   logic [3:0]  row_nx, addr_nx;
   logic [5:0]  pix, pix_nx, pix_in;
   logic        pclk_nx, lat_nx, oe_n_nx, fd_nx;

   assign pix_in = {R0, G0, B0, R1, G1, B1};
   assign {pR0, pG0, pB0, pR1, pG1, pB1} = pix;

   // State and all output registers; reset forces panel dark and unlatched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ph         <= 1'b0;
         col        <= '0;
         row        <= '0;
         addr       <= '0;
         pix        <= '0;
         pclk       <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         ph         <= ph_nx;
         col        <= col_nx;
         row        <= row_nx;
         addr       <= addr_nx;
         pix        <= pix_nx;
         pclk       <= pclk_nx;
         lat        <= lat_nx;
         oe_n       <= oe_n_nx;
         frame_done <= fd_nx;
      end
   end

   // Next-state and next-output logic for the scan sequence.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ph_nx    = ph;
      col_nx   = col;
      row_nx   = row;
      addr_nx  = addr;
      pix_nx   = pix;
      pclk_nx  = pclk;
      lat_nx   = lat;
      oe_n_nx  = oe_n;
      fd_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            pclk_nx = 1'b0;
            oe_n_nx = 1'b1;
            lat_nx  = 1'b0;
            col_nx  = '0;
            if (en) begin
               state_nx = SHIFT;
               cnt_nx   = '0;
               ph_nx    = 1'b0;
               pix_nx   = pix_in;
            end
         end
         SHIFT: begin
            if (cnt == DIV_LAST) begin
               cnt_nx = '0;
               if (!ph) begin
                  ph_nx   = 1'b1;
                  pclk_nx = 1'b1;
                  col_nx  = (col == COL_LAST) ? 6'd0 : col + 6'd1;
               end else if (col == 6'd0) begin
                  // last column's high phase is over: latch the row
                  state_nx = LATCH;
                  ph_nx    = 1'b0;
                  pclk_nx  = 1'b0;
                  lat_nx   = 1'b1;
                  addr_nx  = row;
                  row_nx   = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
               end else begin
                  ph_nx   = 1'b0;
                  pclk_nx = 1'b0;
                  pix_nx  = pix_in;
               end
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         LATCH: begin
            state_nx = DISPLAY;
            lat_nx   = 1'b0;
            oe_n_nx  = 1'b0;
            cnt_nx   = '0;
         end
         DISPLAY: begin
            if (cnt == ON_LAST) begin
               state_nx = BLANK;
               oe_n_nx  = 1'b1;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         BLANK: begin
            if (cnt == BL_LAST) begin
               cnt_nx = '0;
               fd_nx  = (row == 4'd0);
               if (en) begin
                  state_nx = SHIFT;
                  ph_nx    = 1'b0;
                  pclk_nx  = 1'b0;
                  pix_nx   = pix_in;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: default geometry plus a small
// CLK_DIV=3 instance, each driven by a simple pixel model.
module tb_hub75_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic en3 = 1'b0;

   always #5 clk = ~clk;

   logic [5:0] col;
   logic [3:0] row, addr;
   logic R0, G0, B0, R1, G1, B1;
   logic pR0, pG0, pB0, pR1, pG1, pB1;
   logic pclk, lat, oe_n, frame_done;

   logic [5:0] col3;
   logic [3:0] row3, addr3;
   logic R0_3, G0_3, B0_3, R1_3, G1_3, B1_3;
   logic pR0_3, pG0_3, pB0_3, pR1_3, pG1_3, pB1_3;
   logic pclk3, lat3, oe_n3, fd3;

   // pixel models
   assign R0 = col[0];
   assign G0 = 1'b0;
   assign B0 = 1'b0;
   assign R1 = col[1];
   assign G1 = row[0];
   assign B1 = ~col[0];

   assign R0_3 = col3[0];
   assign G0_3 = col3[1];
   assign B0_3 = 1'b0;
   assign R1_3 = 1'b0;
   assign G1_3 = row3[0];
   assign B1_3 = 1'b0;

   hub75_scan_driver dut (
      .clk(clk), .rst(rst), .en(en), .col(col), .row(row),
      .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
      .pR0(pR0), .pG0(pG0), .pB0(pB0),
      .pR1(pR1), .pG1(pG1), .pB1(pB1),
      .pclk(pclk), .lat(lat), .oe_n(oe_n), .addr(addr),
      .frame_done(frame_done)
   );

   hub75_scan_driver #(
      .COLS(4), .ROWS(2), .CLK_DIV(3), .ON_CYC(5), .BLANK_CYC(2)
   ) u3 (
      .clk(clk), .rst(rst), .en(en3), .col(col3), .row(row3),
      .R0(R0_3), .G0(G0_3), .B0(B0_3), .R1(R1_3), .G1(G1_3), .B1(B1_3),
      .pR0(pR0_3), .pG0(pG0_3), .pB0(pB0_3),
      .pR1(pR1_3), .pG1(pG1_3), .pB1(pB1_3),
      .pclk(pclk3), .lat(lat3), .oe_n(oe_n3), .addr(addr3),
      .frame_done(fd3)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int rises, dbad, tbad, lat0, lat0_at, lat0_addr, lat0_row;
   int oe0, oe0_first, oe0_last, nlat, seqbad, nfd, fd_at, row_fd;
   int viol, late, bad;
   logic prev;
   int r3, tb3, db3, hi3, chg3, lb3, nlat3, nfd3, fd3_at;
   logic prev3;
   logic [5:0] pix3, ppix3;

   initial begin
      // reset and idle
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_col", col, 0);
      chk("rst_row", row, 0);
      chk("rst_addr", addr, 0);
      chk("rst_pix", {pR0, pG0, pB0, pR1, pG1, pB1}, 0);
      chk("rst_pclk", pclk, 0);
      chk("rst_lat", lat, 0);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_fd", frame_done, 0);
      chk("rst_oe_n3", oe_n3, 1);
      rst = 1'b0;
      bad = 0;
      repeat (50) begin
         tick();
         if (pclk || lat || !oe_n || col != 0 || frame_done) bad++;
      end
      chk("idle_quiet", bad, 0);

      // first row and full frame, default geometry
      rises = 0; dbad = 0; tbad = 0; lat0 = 0; lat0_at = -1;
      lat0_addr = -1; lat0_row = -1; oe0 = 0; oe0_first = -1;
      oe0_last = -1; nlat = 0; seqbad = 0; nfd = 0; fd_at = -1;
      row_fd = -1; viol = 0; prev = 1'b0;
      en = 1'b1;
      for (int t = 0; t <= 6353; t++) begin
         tick();
         if (pclk && !prev && t < 389) begin
            if (pR0 !== rises[0] || pB1 !== ~rises[0]) dbad++;
            if (t != 2 * rises + 1) tbad++;
            rises++;
         end
         prev = pclk;
         if (lat) begin
            if (pclk) viol++;
            if (t < 389) begin
               lat0++; lat0_at = t;
               lat0_addr = int'(addr); lat0_row = int'(row);
            end
            if (int'(addr) != nlat % 16) seqbad++;
            nlat++;
         end
         if (!oe_n) begin
            if (lat || pclk) viol++;
            if (t < 389) begin
               oe0++;
               if (oe0_first < 0) oe0_first = t;
               oe0_last = t;
            end
         end
         if (frame_done) begin
            nfd++; fd_at = t;
         end
         if (t == 6224) row_fd = int'(row);
      end
      chk("row0_rises", rises, 64);
      chk("row0_data", dbad, 0);
      chk("row0_rise_time", tbad, 0);
      chk("row0_lat_cnt", lat0, 1);
      chk("row0_lat_at", lat0_at, 128);
      chk("row0_lat_addr", lat0_addr, 0);
      chk("row0_lat_row", lat0_row, 1);
      chk("row0_oe_low", oe0, 256);
      chk("row0_oe_first", oe0_first, 129);
      chk("row0_oe_last", oe0_last, 384);
      chk("frame_lats", nlat, 17);
      chk("frame_addr_seq", seqbad, 0);
      chk("frame_fd_cnt", nfd, 1);
      chk("frame_fd_at", fd_at, 6224);
      chk("frame_row_wrap", row_fd, 0);
      chk("oe_lat_pclk_excl", viol, 0);

      // en dropped mid-shift: row completes then idles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b1;
      rises = 0; lat0 = 0; oe0 = 0; late = 0; prev = 1'b0;
      for (int t = 0; t <= 500; t++) begin
         tick();
         if (t == 20) en = 1'b0;
         if (pclk && !prev) rises++;
         prev = pclk;
         if (lat) lat0++;
         if (!oe_n) oe0++;
         if (t >= 389 && (pclk || !oe_n || col != 0)) late++;
      end
      chk("drop_rises", rises, 64);
      chk("drop_lat", lat0, 1);
      chk("drop_oe_low", oe0, 256);
      chk("drop_idle", late, 0);

      // reset during display of row 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b1;
      for (int t = 0; t <= 589; t++) tick();
      chk("disp_oe_n", oe_n, 0);
      chk("disp_addr", addr, 1);
      chk("disp_row", row, 2);
      #3 rst = 1'b1;
      #1;
      chk("arst_oe_n", oe_n, 1);
      chk("arst_lat", lat, 0);
      chk("arst_addr", addr, 0);
      chk("arst_row", row, 0);
      chk("arst_col", col, 0);
      #1 rst = 1'b0;
      tick();
      chk("restart_col", col, 0);
      chk("restart_pclk", pclk, 0);
      chk("restart_oe_n", oe_n, 1);
      tick();
      chk("restart_rise", pclk, 1);
      chk("restart_col1", col, 1);
      chk("restart_pB1", pB1, 1);
      repeat (127) tick();
      chk("restart_lat", lat, 1);
      chk("restart_lat_addr", addr, 0);
      chk("restart_lat_row", row, 1);

      // CLK_DIV=3 instance: 4 cols, 2 rows, row period 32
      en = 1'b0;
      r3 = 0; tb3 = 0; db3 = 0; hi3 = 0; chg3 = 0; lb3 = 0;
      nlat3 = 0; nfd3 = 0; fd3_at = -1; prev3 = pclk3;
      ppix3 = {pR0_3, pG0_3, pB0_3, pR1_3, pG1_3, pB1_3};
      en3 = 1'b1;
      for (int t = 0; t <= 64; t++) begin
         tick();
         if (pclk3 && !prev3) begin
            if (t != 6 * (r3 % 4) + 3 + 32 * (r3 / 4)) tb3++;
            if (pR0_3 !== r3[0] || pG0_3 !== r3[1]) db3++;
            r3++;
         end
         prev3 = pclk3;
         if (pclk3) hi3++;
         pix3 = {pR0_3, pG0_3, pB0_3, pR1_3, pG1_3, pB1_3};
         if (pix3 != ppix3 && !((t % 32) inside {0, 6, 12, 18})) chg3++;
         ppix3 = pix3;
         if (lat3) begin
            nlat3++;
            if (t != 24 && t != 56) lb3++;
         end
         if (fd3) begin
            nfd3++; fd3_at = t;
         end
      end
      chk("div3_rises", r3, 8);
      chk("div3_rise_time", tb3, 0);
      chk("div3_data", db3, 0);
      chk("div3_high_cycles", hi3, 24);
      chk("div3_data_change", chg3, 0);
      chk("div3_lat_cnt", nlat3, 2);
      chk("div3_lat_time", lb3, 0);
      chk("div3_fd_cnt", nfd3, 1);
      chk("div3_fd_at", fd3_at, 64);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
